// File: rtl/reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : reorder_buffer                                               |
// | Description : In-order retirement buffer. Entries are allocated in program |
// |               order, completed out of order by tag, and retired one per    |
// |               cycle onto the register file write port.                     |
// |               Optional macro ROB_CMPL_BYPASS_EN: head completion retires   |
// |               at the same edge using the incoming completion data.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module reorder_buffer #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic              alloc_wr_en,
  input  logic [4:0]        alloc_rd,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic [DATA_W-1:0] cmpl_data,
  output logic              commit_valid,
  output logic              commit_we,
  output logic [4:0]        commit_rd,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

  logic [TAG_W:0]      head;
  logic [TAG_W:0]      tail;
  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    done;
  logic [DEPTH-1:0]    wr_en_mem;
  logic [4:0]          rd_mem   [DEPTH];
  logic [DATA_W-1:0]   data_mem [DEPTH];

  logic [TAG_W-1:0]    head_idx;
  logic [TAG_W-1:0]    tail_idx;
  logic                full;
  logic                do_alloc;
  logic                do_cmpl;
  logic                do_retire;
  logic [DATA_W-1:0]   retire_data;

  assign head_idx    = head[TAG_W-1:0];
  assign tail_idx    = tail[TAG_W-1:0];
  assign full        = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);
  assign empty       = (head == tail);
  assign count       = tail - head;
  assign alloc_ready = !full;
  assign alloc_tag   = tail_idx;

  assign do_alloc = alloc_valid && !full;
  // A completion only lands on an entry that was already busy before this edge.
  assign do_cmpl  = cmpl_valid && busy[cmpl_tag];

`ifdef ROB_CMPL_BYPASS_EN
  logic head_bypass;
  assign head_bypass = busy[head_idx] && !done[head_idx] && cmpl_valid && (cmpl_tag == head_idx);
  assign do_retire   = (busy[head_idx] && done[head_idx]) || head_bypass;
  assign retire_data = head_bypass ? cmpl_data : data_mem[head_idx];
`else
  assign do_retire   = busy[head_idx] && done[head_idx];
  assign retire_data = data_mem[head_idx];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      busy         <= '0;
      done         <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
      commit_rd    <= '0;
      commit_data  <= '0;
    end else if (flush) begin
      head         <= '0;
      tail         <= '0;
      busy         <= '0;
      done         <= '0;
      commit_valid <= 1'b0;
      commit_we    <= 1'b0;
    end else begin
      if (do_cmpl) begin
        done[cmpl_tag] <= 1'b1;
      end
      // Retire clears after the completion update so a bypassed head ends up free.
      if (do_retire) begin
        busy[head_idx] <= 1'b0;
        done[head_idx] <= 1'b0;
        head           <= head + PTR_ONE;
        commit_valid   <= 1'b1;
        commit_we      <= wr_en_mem[head_idx] && (rd_mem[head_idx] != 5'd0);
        commit_rd      <= rd_mem[head_idx];
        commit_data    <= retire_data;
      end else begin
        commit_valid   <= 1'b0;
        commit_we      <= 1'b0;
      end
      if (do_alloc) begin
        busy[tail_idx] <= 1'b1;
        done[tail_idx] <= 1'b0;
        tail           <= tail + PTR_ONE;
      end
    end
  end

  // Payload storage needs no reset; validity lives entirely in busy/done.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      wr_en_mem[tail_idx] <= alloc_wr_en;
      rd_mem[tail_idx]    <= alloc_rd;
    end
    if (do_cmpl) begin
      data_mem[cmpl_tag] <= cmpl_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_reorder_buffer                                            |
// | Description : Self-checking bench for reorder_buffer with commit scoreboard|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_reorder_buffer;

`ifdef ROB_CMPL_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic        alloc_wr_en;
  logic [4:0]  alloc_rd;
  logic [2:0]  alloc_tag;
  logic        cmpl_valid;
  logic [2:0]  cmpl_tag;
  logic [31:0] cmpl_data;
  logic        commit_valid;
  logic        commit_we;
  logic [4:0]  commit_rd;
  logic [31:0] commit_data;
  logic [3:0]  count;
  logic        empty;

  reorder_buffer #(.DEPTH(8), .TAG_W(3), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_wr_en(alloc_wr_en),
    .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
    .commit_data(commit_data), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } commit_t;

  typedef struct {
    logic        wr_en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exp_we;
  } vec_t;

  commit_t     exp_q[$];
  logic [31:0] plan [8];
  logic [2:0]  m_tail;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and score any commit that appeared on this edge.
  task automatic tick;
    commit_t e;
    @(posedge clk);
    #1;
    if (commit_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_commit", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_commit_we", commit_we, e.we);
        chk("sb_commit_rd", commit_rd, e.rd);
        chk("sb_commit_data", commit_data, e.data);
      end
    end
  endtask

  task automatic set_alloc(input logic wr, input logic [4:0] rd, input logic [31:0] data);
    commit_t e;
    chk("alloc_ready", alloc_ready, 1'b1);
    chk("alloc_tag", alloc_tag, m_tail);
    alloc_valid = 1'b1;
    alloc_wr_en = wr;
    alloc_rd    = rd;
    e.we = wr && (rd != 5'd0);
    e.rd = rd;
    e.data = data;
    exp_q.push_back(e);
    plan[m_tail] = data;
    m_tail = m_tail + 3'd1;
  endtask

  task automatic alloc(input logic wr, input logic [4:0] rd, input logic [31:0] data);
    set_alloc(wr, rd, data);
    tick;
    alloc_valid = 1'b0;
  endtask

  task automatic complete(input logic [2:0] tag, input logic [31:0] data);
    cmpl_valid = 1'b1;
    cmpl_tag   = tag;
    cmpl_data  = data;
    tick;
    cmpl_valid = 1'b0;
  endtask

  vec_t vecs[4];
  int   order[8];
  logic [2:0] tg;

  initial begin
    vecs[0] = '{wr_en: 1'b1, rd: 5'd5,  data: 32'h0000_000A, exp_we: 1'b1};
    vecs[1] = '{wr_en: 1'b1, rd: 5'd0,  data: 32'h0000_0055, exp_we: 1'b0};
    vecs[2] = '{wr_en: 1'b0, rd: 5'd9,  data: 32'h0000_0055, exp_we: 1'b0};
    vecs[3] = '{wr_en: 1'b1, rd: 5'd31, data: 32'hFFFF_FFFF, exp_we: 1'b1};
    order   = '{2, 1, 0, 7, 6, 5, 4, 3};

    reset = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_wr_en = 1'b0; alloc_rd = '0;
    cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = '0; m_tail = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alloc_ready", alloc_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", count, 4'd0);
    chk("rst_alloc_tag", alloc_tag, 3'd0);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_commit_we", commit_we, 1'b0);
    chk("rst_commit_rd", commit_rd, 5'd0);
    chk("rst_commit_data", commit_data, 32'd0);
    reset = 1'b0;

    // Out-of-order completion, in-order retirement
    alloc(1'b1, 5'd5, 32'hA);
    alloc(1'b1, 5'd6, 32'hB);
    alloc(1'b1, 5'd7, 32'hC);
    chk("s1_count", count, 4'd3);
    chk("s1_empty", empty, 1'b0);
    tick;
    chk("s1_no_commit_idle", commit_valid, 1'b0);
    complete(3'd2, 32'hC);
    chk("s1_no_commit_tag2", commit_valid, 1'b0);
    complete(3'd0, 32'hA);
    chk("s1_cv_after_tag0", commit_valid, (LAT == 0));
    complete(3'd1, 32'hB);
    chk("s1_cv_after_tag1", commit_valid, 1'b1);
    tick;
    chk("s1_cv_next", commit_valid, 1'b1);
    repeat (LAT) begin
      tick;
      chk("s1_cv_last", commit_valid, 1'b1);
    end
    tick;
    chk("s1_cv_done", commit_valid, 1'b0);
    chk("s1_empty_done", empty, 1'b1);

    // Fill to full across the wrap point
    for (int i = 0; i < 8; i++) alloc(1'b1, 5'(8 + i), 32'h100 + i);
    chk("s3_count_full", count, 4'd8);
    chk("s3_ready_full", alloc_ready, 1'b0);
    alloc_valid = 1'b1;
    tick;
    alloc_valid = 1'b0;
    chk("s3_count_blocked", count, 4'd8);
    complete(3'd3, plan[3]);
    repeat (LAT) tick;
    chk("s3_retire_cv", commit_valid, 1'b1);
    chk("s3_count_after", count, 4'd7);
    chk("s3_ready_after", alloc_ready, 1'b1);
    alloc(1'b1, 5'd20, 32'h200);
    chk("s3_count_refull", count, 4'd8);
    for (int i = 0; i < 8; i++) complete(3'(order[i]), plan[order[i]]);
    repeat (12) tick;
    chk("s3_drained_empty", empty, 1'b1);
    chk("s3_drained_q", exp_q.size(), 0);

    // Completions to idle entries and same-cycle allocate are ignored
    complete(m_tail, 32'hDEAD);
    chk("s_idle_cmpl_count", count, 4'd0);
    tg = m_tail;
    cmpl_valid = 1'b1; cmpl_tag = tg; cmpl_data = 32'hBEEF;
    set_alloc(1'b1, 5'd21, 32'h300);
    tick;
    alloc_valid = 1'b0; cmpl_valid = 1'b0;
    repeat (3) tick;
    chk("s_same_cycle_cmpl_cv", commit_valid, 1'b0);
    chk("s_same_cycle_count", count, 4'd1);
    complete(tg, 32'h300);
    repeat (LAT) tick;
    chk("s_same_cycle_retire", commit_valid, 1'b1);
    tick;

    // rd=0 and wr_en=0 suppress the register file write
    foreach (vecs[i]) begin
      tg = m_tail;
      alloc(vecs[i].wr_en, vecs[i].rd, vecs[i].data);
      complete(tg, vecs[i].data);
      repeat (LAT) tick;
      chk("v_commit_valid", commit_valid, 1'b1);
      chk("v_commit_we", commit_we, vecs[i].exp_we);
      chk("v_commit_rd", commit_rd, vecs[i].rd);
      chk("v_commit_data", commit_data, vecs[i].data);
      tick;
      chk("v_idle_cv", commit_valid, 1'b0);
      chk("v_idle_we", commit_we, 1'b0);
      chk("v_hold_rd", commit_rd, vecs[i].rd);
      chk("v_hold_data", commit_data, vecs[i].data);
    end

    // Flush wins over alloc/complete
    tg = m_tail;
    for (int i = 0; i < 4; i++) alloc(1'b1, 5'(10 + i), 32'h40 + i);
    complete(tg + 3'd1, plan[tg + 3'd1]);
    complete(tg + 3'd3, plan[tg + 3'd3]);
    chk("s5_count", count, 4'd4);
    exp_q.delete();
    flush = 1'b1; alloc_valid = 1'b1; cmpl_valid = 1'b1; cmpl_tag = tg; cmpl_data = 32'h99;
    tick;
    flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0;
    m_tail = '0;
    chk("s5_count_flush", count, 4'd0);
    chk("s5_empty_flush", empty, 1'b1);
    chk("s5_cv_flush", commit_valid, 1'b0);
    chk("s5_tag_flush", alloc_tag, 3'd0);
    repeat (2) tick;
    chk("s5_cv_quiet", commit_valid, 1'b0);

    // Allocate and retire on the same edge keep count steady
    alloc(1'b1, 5'd14, 32'h400);
    cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h400;
    repeat (LAT) begin
      tick;
      cmpl_valid = 1'b0;
    end
    set_alloc(1'b1, 5'd15, 32'h401);
    tick;
    alloc_valid = 1'b0; cmpl_valid = 1'b0;
    chk("s_ar_cv", commit_valid, 1'b1);
    chk("s_ar_count", count, 4'd1);
    complete(3'd1, 32'h401);
    repeat (3) tick;
    chk("s_ar_empty", empty, 1'b1);

    // Asynchronous reset mid-operation
    tg = m_tail;
    alloc(1'b1, 5'd16, 32'h500);
    alloc(1'b1, 5'd17, 32'h501);
    complete(tg, 32'h500);
    exp_q.delete();
    #2 reset = 1'b1;
    #1;
    chk("arst_cv", commit_valid, 1'b0);
    chk("arst_count", count, 4'd0);
    chk("arst_empty", empty, 1'b1);
    chk("arst_ready", alloc_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
    m_tail = '0;
    tick;
    chk("arst_after_cv", commit_valid, 1'b0);

`ifdef ROB_CMPL_BYPASS_EN
    alloc(1'b1, 5'd3, 32'h77);
    complete(3'd0, 32'h77);
    chk("byp_cv", commit_valid, 1'b1);
    chk("byp_rd", commit_rd, 5'd3);
    chk("byp_data", commit_data, 32'h77);
`endif

    repeat (4) tick;
    chk("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
